// File: rtl/mem_req_arbiter.sv
// N-channel val/rdy memory request arbiter (fixed or round-robin) with an in-order
// tag FIFO that routes each memory response back to the channel that issued it.
module mem_req_arbiter #(
  parameter int unsigned NCH       = 2,
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned RR        = 0,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NCH-1:0]          i_ch_req_val,
  output logic [NCH-1:0]          o_ch_req_rdy,
  input  logic [NCH-1:0]          i_ch_req_type,
  input  logic [NCH*AW-1:0]       i_ch_req_addr,
  input  logic [NCH*DW-1:0]       i_ch_req_wdata,
  output logic [NCH-1:0]          o_ch_resp_val,
  output logic [NCH*DW-1:0]       o_ch_resp_rdata,
  output logic                    o_mem_req_val,
  input  logic                    i_mem_req_rdy,
  output logic                    o_mem_req_type,
  output logic [AW-1:0]           o_mem_req_addr,
  output logic [DW-1:0]           o_mem_req_wdata,
  input  logic                    i_mem_resp_val,
  input  logic [DW-1:0]           i_mem_resp_rdata,
  output logic [$clog2(NCH)-1:0]  o_grant_id,
  output logic                    o_err_orphan
);

  localparam int unsigned CW = $clog2(NCH);
  localparam int unsigned PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int unsigned NW = $clog2(MAX_OUTST + 1);

  logic [CW-1:0] r_rr_ptr;
  logic [CW-1:0] r_tag [MAX_OUTST];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [NW-1:0] r_cnt;
  logic          r_err_orphan;

  logic [CW-1:0] w_win;
  logic [CW-1:0] w_cand;
  logic          w_any;
  logic          w_full;
  logic          w_fire;
  logic          w_pop;

  // (a + k) mod NCH, valid for a < NCH and k <= NCH
  function automatic logic [CW-1:0] wrap_add(input logic [CW-1:0] a, input int unsigned k);
    int unsigned s;
    s = 32'(a) + k;
    if (s >= NCH) s = s - NCH;
    return CW'(s);
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (32'(p) == MAX_OUTST - 1) ? '0 : p + 1'b1;
  endfunction

  // First valid channel in search order: 0..NCH-1 (fixed) or rr_ptr upward (RR)
  always_comb begin
    w_win  = '0;
    w_cand = '0;
    w_any  = 1'b0;
    for (int unsigned k = 0; k < NCH; k++) begin
      w_cand = (RR != 0) ? wrap_add(r_rr_ptr, k) : CW'(k);
      if (!w_any && i_ch_req_val[w_cand]) begin
        w_any = 1'b1;
        w_win = w_cand;
      end
    end
  end

  assign w_full        = (r_cnt == NW'(MAX_OUTST));
  assign o_mem_req_val = w_any & ~w_full;
  assign w_fire        = o_mem_req_val & i_mem_req_rdy;
  assign w_pop         = i_mem_resp_val & (r_cnt != '0);
  assign o_err_orphan  = r_err_orphan;
  assign o_grant_id    = w_win;

  always_comb begin
    o_ch_req_rdy         = '0;
    o_ch_req_rdy[w_win]  = w_fire;
    o_mem_req_type       = i_ch_req_type[w_win];
    o_mem_req_addr       = i_ch_req_addr[w_win*AW +: AW];
    o_mem_req_wdata      = i_ch_req_wdata[w_win*DW +: DW];
    o_ch_resp_val        = '0;
    o_ch_resp_rdata      = '0;
    if (w_pop) begin
      o_ch_resp_val[r_tag[r_head]]              = 1'b1;
      o_ch_resp_rdata[r_tag[r_head]*DW +: DW]   = i_mem_resp_rdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rr_ptr     <= '0;
      r_head       <= '0;
      r_tail       <= '0;
      r_cnt        <= '0;
      r_err_orphan <= 1'b0;
      for (int unsigned i = 0; i < MAX_OUTST; i++) r_tag[i] <= '0;
    end else begin
      if (w_fire) begin
        r_tag[r_tail] <= w_win;
        r_tail        <= ptr_inc(r_tail);
        if (RR != 0) r_rr_ptr <= wrap_add(w_win, 1);
      end
      if (w_pop) r_head <= ptr_inc(r_head);
      if (w_fire && !w_pop) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (!w_fire && w_pop) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (i_mem_resp_val && (r_cnt == '0)) r_err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: a fixed-priority 2-channel and a round-robin 3-channel
// instance, exercised by a vector table, directed sequences and a randomized model run.
module tb_mem_req_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        sel;  // 0: fixed instance active, 1: round-robin instance active
  logic [2:0]  d_val;
  logic [2:0]  d_typ;
  logic [95:0] d_addr;
  logic [95:0] d_wdata;
  logic        d_mrdy;
  logic        d_rval;
  logic [31:0] d_rdata;

  logic [1:0]  fx_val, fx_rdy, fx_rval;
  logic [63:0] fx_rdata;
  logic        fx_rv, fx_mval, fx_mtyp, fx_err;
  logic [31:0] fx_maddr, fx_mwdata;
  logic [0:0]  fx_gid;

  logic [2:0]  rr_val, rr_rdy, rr_rval;
  logic [95:0] rr_rdata;
  logic        rr_rv, rr_mval, rr_mtyp, rr_err;
  logic [31:0] rr_maddr, rr_mwdata;
  logic [1:0]  rr_gid;

  assign fx_val = sel ? 2'b00 : d_val[1:0];
  assign fx_rv  = d_rval & ~sel;
  assign rr_val = sel ? d_val : 3'b000;
  assign rr_rv  = d_rval & sel;

  mem_req_arbiter #(.NCH(2), .AW(32), .DW(32), .RR(0), .MAX_OUTST(2)) u_fix (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_ch_req_val(fx_val), .o_ch_req_rdy(fx_rdy), .i_ch_req_type(d_typ[1:0]),
    .i_ch_req_addr(d_addr[63:0]), .i_ch_req_wdata(d_wdata[63:0]),
    .o_ch_resp_val(fx_rval), .o_ch_resp_rdata(fx_rdata),
    .o_mem_req_val(fx_mval), .i_mem_req_rdy(d_mrdy), .o_mem_req_type(fx_mtyp),
    .o_mem_req_addr(fx_maddr), .o_mem_req_wdata(fx_mwdata),
    .i_mem_resp_val(fx_rv), .i_mem_resp_rdata(d_rdata),
    .o_grant_id(fx_gid), .o_err_orphan(fx_err)
  );

  mem_req_arbiter #(.NCH(3), .AW(32), .DW(32), .RR(1), .MAX_OUTST(2)) u_rr (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_ch_req_val(rr_val), .o_ch_req_rdy(rr_rdy), .i_ch_req_type(d_typ),
    .i_ch_req_addr(d_addr), .i_ch_req_wdata(d_wdata),
    .o_ch_resp_val(rr_rval), .o_ch_resp_rdata(rr_rdata),
    .o_mem_req_val(rr_mval), .i_mem_req_rdy(d_mrdy), .o_mem_req_type(rr_mtyp),
    .o_mem_req_addr(rr_maddr), .o_mem_req_wdata(rr_mwdata),
    .i_mem_resp_val(rr_rv), .i_mem_resp_rdata(d_rdata),
    .o_grant_id(rr_gid), .o_err_orphan(rr_err)
  );

  logic [2:0]  ob_rdy, ob_rval;
  logic [95:0] ob_rdata;
  logic        ob_mval, ob_mtyp, ob_err;
  logic [31:0] ob_maddr, ob_mwdata;
  logic [1:0]  ob_gid;

  assign ob_rdy    = sel ? rr_rdy    : {1'b0, fx_rdy};
  assign ob_rval   = sel ? rr_rval   : {1'b0, fx_rval};
  assign ob_rdata  = sel ? rr_rdata  : {32'h0, fx_rdata};
  assign ob_mval   = sel ? rr_mval   : fx_mval;
  assign ob_mtyp   = sel ? rr_mtyp   : fx_mtyp;
  assign ob_maddr  = sel ? rr_maddr  : fx_maddr;
  assign ob_mwdata = sel ? rr_mwdata : fx_mwdata;
  assign ob_gid    = sel ? rr_gid    : {1'b0, fx_gid};
  assign ob_err    = sel ? rr_err    : fx_err;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  function automatic logic [95:0] pk(input int ch, input logic [31:0] d);
    logic [95:0] r;
    r = '0;
    if (ch >= 0) r[ch*32 +: 32] = d;
    return r;
  endfunction

  function automatic logic [2:0] oh(input int ch);
    return (ch >= 0) ? (3'b001 << ch) : 3'b000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] v, input logic [2:0] t, input logic mr,
                       input logic rv, input logic [31:0] rd);
    d_val = v; d_typ = t; d_mrdy = mr; d_rval = rv; d_rdata = rd;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    d_val = '0; d_rval = 1'b0; d_mrdy = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    logic [2:0]  val;
    logic [2:0]  typ;
    logic        mrdy;
    logic        rval;
    logic [31:0] rdata;
    logic        e_mval;
    logic [1:0]  e_gid;
    logic [2:0]  e_rdy;
    int          e_rch;
    logic        e_err;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] v, input logic [2:0] t, input logic mr,
                              input logic rv, input logic [31:0] rd, input logic em,
                              input logic [1:0] eg, input logic [2:0] er, input int rch,
                              input logic ee);
    vec_t x;
    x.val = v; x.typ = t; x.mrdy = mr; x.rval = rv; x.rdata = rd;
    x.e_mval = em; x.e_gid = eg; x.e_rdy = er; x.e_rch = rch; x.e_err = ee;
    return x;
  endfunction

  // Reference model state: in-order queue of issuing channels, RR pointer, sticky error
  int mq[$];
  int m_ptr;
  bit m_err;

  task automatic model_step(input int nch, input bit rr, input string tag);
    int          win, c;
    bit          any, full, pop;
    logic [2:0]  e_rdy, e_rval;
    logic [95:0] e_rdata;
    int          qsz;
    win = 0; any = 0;
    for (int k = 0; k < nch; k++) begin
      c = rr ? (m_ptr + k) % nch : k;
      if (!any && d_val[c]) begin any = 1; win = c; end
    end
    qsz     = mq.size();
    full    = (qsz == 2);
    pop     = d_rval && (qsz > 0);
    e_rdy   = (any && d_mrdy && !full) ? oh(win) : 3'b000;
    e_rval  = pop ? oh(mq[0]) : 3'b000;
    e_rdata = pop ? pk(mq[0], d_rdata) : '0;
    chk({tag, " mval"}, ob_mval, any && !full);
    chk({tag, " gid"}, ob_gid, any ? win : 0);
    chk({tag, " rdy"}, ob_rdy, e_rdy);
    chk({tag, " rval"}, ob_rval, e_rval);
    chk({tag, " rdata"}, ob_rdata, e_rdata);
    chk({tag, " err"}, ob_err, m_err);
    if (any) begin
      chk({tag, " addr"}, ob_maddr, d_addr[win*32 +: 32]);
      chk({tag, " wdata"}, ob_mwdata, d_wdata[win*32 +: 32]);
      chk({tag, " type"}, ob_mtyp, d_typ[win]);
    end
    if (pop) void'(mq.pop_front());
    if (any && !full && d_mrdy) begin
      mq.push_back(win);
      if (rr) m_ptr = (win + 1) % nch;
    end
    if (d_rval && qsz == 0) m_err = 1;
  endtask

  vec_t vt[16];
  int   gexp[6];

  initial begin
    sel = 1'b0; d_typ = '0; d_rdata = '0;
    d_addr  = {32'h300, 32'h200, 32'h100};
    d_wdata = {32'h1002, 32'h1001, 32'h1000};

    // ---- Vector table on the fixed-priority 2-channel instance ----
    vt[0]  = mk(3'b000, 3'b000, 1, 0, 0,          0, 0, 3'b000, -1, 0);
    vt[1]  = mk(3'b011, 3'b000, 1, 0, 0,          1, 0, 3'b001, -1, 0);
    vt[2]  = mk(3'b010, 3'b000, 1, 0, 0,          1, 1, 3'b010, -1, 0);
    vt[3]  = mk(3'b000, 3'b000, 1, 1, 32'hAAAA,   0, 0, 3'b000,  0, 0);
    vt[4]  = mk(3'b000, 3'b000, 1, 1, 32'hBBBB,   0, 0, 3'b000,  1, 0);
    vt[5]  = mk(3'b001, 3'b001, 1, 0, 0,          1, 0, 3'b001, -1, 0);
    vt[6]  = mk(3'b010, 3'b000, 1, 0, 0,          1, 1, 3'b010, -1, 0);
    vt[7]  = mk(3'b001, 3'b000, 1, 0, 0,          0, 0, 3'b000, -1, 0);
    vt[8]  = mk(3'b001, 3'b000, 1, 1, 32'h11,     0, 0, 3'b000,  0, 0);
    vt[9]  = mk(3'b001, 3'b000, 1, 0, 0,          1, 0, 3'b001, -1, 0);
    vt[10] = mk(3'b000, 3'b000, 1, 1, 32'h22,     0, 0, 3'b000,  1, 0);
    vt[11] = mk(3'b010, 3'b000, 1, 1, 32'h33,     1, 1, 3'b010,  0, 0);
    vt[12] = mk(3'b000, 3'b000, 1, 1, 32'h44,     0, 0, 3'b000,  1, 0);
    vt[13] = mk(3'b000, 3'b000, 1, 1, 32'h55,     0, 0, 3'b000, -1, 0);
    vt[14] = mk(3'b000, 3'b000, 1, 0, 0,          0, 0, 3'b000, -1, 1);
    vt[15] = mk(3'b011, 3'b000, 0, 0, 0,          1, 0, 3'b000, -1, 1);

    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(vt[i].val, vt[i].typ, vt[i].mrdy, vt[i].rval, vt[i].rdata);
      chk($sformatf("vec%0d mval", i), ob_mval, vt[i].e_mval);
      chk($sformatf("vec%0d gid", i), ob_gid, vt[i].e_gid);
      chk($sformatf("vec%0d rdy", i), ob_rdy, vt[i].e_rdy);
      chk($sformatf("vec%0d rval", i), ob_rval, oh(vt[i].e_rch));
      chk($sformatf("vec%0d rdata", i), ob_rdata, pk(vt[i].e_rch, vt[i].rdata));
      chk($sformatf("vec%0d err", i), ob_err, vt[i].e_err);
      if (vt[i].e_mval) begin
        chk($sformatf("vec%0d addr", i), ob_maddr, 32'h100 * (vt[i].e_gid + 1));
        chk($sformatf("vec%0d type", i), ob_mtyp, vt[i].typ[vt[i].e_gid]);
        chk($sformatf("vec%0d wdata", i), ob_mwdata, 32'h1000 + vt[i].e_gid);
      end
      tick();
    end

    // ---- Round-robin rotation, response keeps count at one ----
    sel = 1'b1;
    do_reset();
    gexp = '{0, 1, 2, 0, 1, 2};
    for (int c = 0; c < 6; c++) begin
      drive(3'b111, 3'b000, 1, c > 0, 32'hC0 + c);
      chk($sformatf("rr%0d gid", c), ob_gid, gexp[c]);
      chk($sformatf("rr%0d rdy", c), ob_rdy, oh(gexp[c]));
      if (c > 0) begin
        chk($sformatf("rr%0d rval", c), ob_rval, oh(gexp[c-1]));
        chk($sformatf("rr%0d rdata", c), ob_rdata, pk(gexp[c-1], 32'hC0 + c));
      end
      tick();
    end
    drive(3'b000, 3'b000, 1, 1, 32'hD7);
    chk("rr drain rval", ob_rval, 3'b100);
    tick();
    drive(3'b001, 3'b000, 1, 0, 0);
    chk("rr ch0 gid", ob_gid, 0);
    tick();
    drive(3'b101, 3'b000, 1, 0, 0);
    chk("rr skip gid", ob_gid, 2);
    chk("rr skip rdy", ob_rdy, 3'b100);
    tick();
    drive(3'b000, 3'b000, 1, 1, 32'hE0);
    chk("rr resp0", ob_rval, 3'b001);
    tick();
    drive(3'b000, 3'b000, 1, 1, 32'hE1);
    chk("rr resp2", ob_rval, 3'b100);
    tick();

    // ---- Backpressure: held request, no push, pointer untouched ----
    d_addr[63:32] = 32'h300; d_wdata[63:32] = 32'h1234;
    for (int c = 0; c < 3; c++) begin
      drive(3'b010, 3'b010, 0, 0, 0);
      chk($sformatf("bp%0d mval", c), ob_mval, 1'b1);
      chk($sformatf("bp%0d rdy", c), ob_rdy, 3'b000);
      chk($sformatf("bp%0d gid", c), ob_gid, 1);
      chk($sformatf("bp%0d addr", c), ob_maddr, 32'h300);
      chk($sformatf("bp%0d wdata", c), ob_mwdata, 32'h1234);
      chk($sformatf("bp%0d type", c), ob_mtyp, 1'b1);
      tick();
    end
    drive(3'b010, 3'b010, 1, 0, 0);
    chk("bp fire rdy", ob_rdy, 3'b010);
    tick();
    drive(3'b011, 3'b000, 1, 0, 0);
    chk("bp next gid", ob_gid, 0);
    tick();
    drive(3'b000, 3'b000, 1, 1, 32'hF1);
    chk("bp resp1", ob_rval, 3'b010);
    chk("bp resp1 data", ob_rdata, pk(1, 32'hF1));
    tick();
    drive(3'b000, 3'b000, 1, 1, 32'hF2);
    chk("bp resp0", ob_rval, 3'b001);
    tick();

    // ---- Orphan response, sticky flag, asynchronous reset mid-cycle ----
    drive(3'b000, 3'b000, 1, 1, 32'hF3);
    chk("orph rval", ob_rval, 3'b000);
    chk("orph err pre", ob_err, 1'b0);
    tick();
    drive(3'b000, 3'b000, 1, 0, 0);
    chk("orph err set", ob_err, 1'b1);
    tick();
    drive(3'b010, 3'b000, 1, 0, 0);
    chk("orph err sticky", ob_err, 1'b1);
    chk("pre-rst gid", ob_gid, 1);
    tick();
    drive(3'b000, 3'b000, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst err", ob_err, 1'b0);
    chk("rst mval", ob_mval, 1'b0);
    chk("rst rdy", ob_rdy, 3'b000);
    chk("rst gid", ob_gid, 0);
    tick();
    rst_n = 1'b1;
    drive(3'b000, 3'b000, 1, 1, 32'hF4);
    chk("post-rst rval", ob_rval, 3'b000);
    tick();
    drive(3'b111, 3'b000, 1, 0, 0);
    chk("post-rst err", ob_err, 1'b1);
    chk("post-rst gid", ob_gid, 0);
    tick();

    // ---- Randomized run against the reference model, both instances ----
    for (int ph = 0; ph < 2; ph++) begin
      int nch;
      sel = ph[0];
      nch = (ph == 0) ? 2 : 3;
      do_reset();
      mq.delete();
      m_ptr = 0;
      m_err = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
        d_addr  = {$urandom, $urandom, $urandom};
        d_wdata = {$urandom, $urandom, $urandom};
        d_val   = 3'($urandom_range(0, (1 << nch) - 1));
        d_typ   = 3'($urandom_range(0, 7));
        d_mrdy  = ($urandom_range(0, 3) != 0);
        d_rval  = 1'($urandom_range(0, 1));
        d_rdata = $urandom;
        #1;
        model_step(nch, ph == 1, $sformatf("rnd%0d.%0d", ph, cyc));
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
Parametrised N-channel arbiter that merges several val/rdy memory request streams (processor dmem, external test port, future DMA) onto one memory port. It tracks outstanding requests in an in-order tag FIFO and routes each memory response back to the channel that issued it. It replaces the fixed two-way combinational priority mux in front of the processor memory, and adds round-robin mode, backpressure and outstanding-request tracking. It sits between the requesters and the memory block.

Parameters:
NCH, 2, number of requester channels (>=2); channel 0 is highest priority in fixed mode.
AW, 32, address width.
DW, 32, data width.
RR, 0, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin.
MAX_OUTST, 2, tag FIFO depth, i.e. maximum in-flight requests (power of 2, >=1).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-low.
ch_req_val  in  NCH  per-channel request valid.
ch_req_rdy  out  NCH  per-channel request accepted.
ch_req_type  in  NCH  per-channel request type: 0 = read, 1 = write.
ch_req_addr  in  NCH*AW  packed addresses; channel i is at [i*AW +: AW].
ch_req_wdata  in  NCH*DW  packed write data.
ch_resp_val  out  NCH  per-channel response valid.
ch_resp_rdata  out  NCH*DW  packed response data.
mem_req_val  out  1  request to memory.
mem_req_rdy  in  1  memory accepts request.
mem_req_type  out  1  granted request type.
mem_req_addr  out  AW  granted address.
mem_req_wdata  out  DW  granted write data.
mem_resp_val  in  1  memory response valid; every request, read or write, gets exactly one response, in order.
mem_resp_rdata  in  DW  memory response data.
grant_id  out  $clog2(NCH)  index of the current grant; used for trace.
err_orphan  out  1  sticky flag: a response arrived with no outstanding request.

Behaviour:
- State:
  - rr_ptr: highest-priority channel in RR mode.
  - Tag FIFO: MAX_OUTST entries of channel IDs, with head, tail and count.
  - err_orphan.
- Reset (rst=0, asynchronous):
  - rr_ptr=0, FIFO empty (count=0), err_orphan=0.
  - All outputs derive from state and inputs, so during reset with all ch_req_val=0: mem_req_val=0, ch_req_rdy=0, ch_resp_val=0, grant_id=0.
- Grant (combinational, same cycle):
  - Fixed mode: the lowest-index valid channel wins.
  - RR mode: search from rr_ptr upward with wrap at NCH; the first valid channel wins.
- full = (count==MAX_OUTST).
  - mem_req_val = any ch_req_val & !full.
  - mem_req_type, mem_req_addr and mem_req_wdata are muxed from the winner.
  - grant_id = winner; 0 when there is no valid request.
- ch_req_rdy[winner] = mem_req_rdy & !full. All other ch_req_rdy bits are 0. No combinational path from ch_req_val to that channel's own rdy beyond the grant.
- fire = mem_req_val & mem_req_rdy. On fire:
  - Push winner into the FIFO.
  - RR mode: rr_ptr <= (winner+1) mod NCH. rr_ptr is unchanged when there is no fire.
- Response routing (combinational):
  - If mem_resp_val & count>0: ch_resp_val[head] = 1, and ch_resp_rdata for that channel = mem_resp_rdata.
  - Pop on the same edge.
  - ch_resp_rdata for non-responding channels is 0.
- Simultaneous push and pop: count unchanged, head and tail both advance.
  - When full, no push occurs even if a pop happens that cycle (full blocks grant combinationally). This costs at most one bubble.
- Orphan response: mem_resp_val with count=0 sets err_orphan=1 (sticky until reset). No ch_resp_val is asserted and the FIFO is unchanged.
- Pointer wrap: head, tail and rr_ptr wrap modulo the depth or NCH.
- Requester rule: a channel must hold val, type, addr and wdata stable until rdy. The arbiter does not check this.
- Reset mid-operation: in-flight tags are discarded. Responses after reset count as orphans.

Test Plan:
1. NCH=2, RR=0: ch0 and ch1 both request reads (0x100 and 0x200), mem_req_rdy=1 -> ch0 is granted first (mem_req_addr=0x100, ch_req_rdy=01), then ch1 the next cycle. Responses 0xAAAA then 0xBBBB go to ch0 then ch1.
2. NCH=3, RR=1: all three channels hold val for 6 cycles with rdy=1 -> grant_id sequence 0,1,2,0,1,2. With only ch2 valid after a ch0 grant, ch2 is granted immediately.
3. MAX_OUTST=2, no responses: three back-to-back requests -> two fire, then mem_req_val=0 and ch_req_rdy=0. Once one mem_resp_val arrives, the third fires the following cycle.
4. Simultaneous push/pop at count=1: fire plus mem_resp_val in the same cycle -> count stays 1, the response goes to the older tag, and the next response goes to the new channel.
5. mem_req_rdy=0 for 3 cycles with ch1 valid (write 0x300, data 0x1234) -> mem_req_* are held, nothing is pushed, and rr_ptr is unchanged. Fire occurs when rdy rises.
6. mem_resp_val with an empty FIFO -> err_orphan=1 and stays set. Asserting rst low mid-cycle immediately clears err_orphan, count and rr_ptr.
